// File: rtl/fetch_queue.sv
// fetch_queue: IF stage that owns the PC, issues one bus request at a time and
// buffers returned {pc, instr} pairs in a DEPTH-entry FIFO toward decode.
module fetch_queue #(
    parameter int                    PC_WIDTH    = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = PC_WIDTH'(64'h8000_0000)
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         ireq_valid,
    output logic [PC_WIDTH-1:0]          ireq_addr,
    input  logic                         ireq_ready,
    input  logic                         iresp_valid,
    input  logic [INSTR_WIDTH-1:0]       iresp_data,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    output logic                         out_valid,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [INSTR_WIDTH-1:0]       out_instr,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   inflight_pc;
    logic                  outstanding;
    logic                  drop;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic                  accept;
    logic                  resp;
    logic                  push;
    logic                  pop;

    // Credit is taken from the registered count, so out_ready never reaches ireq_valid.
    assign ireq_valid = reset && !outstanding && (count < CW'(DEPTH)) && !redirect_valid;
    assign ireq_addr  = pc;
    assign accept     = ireq_valid && ireq_ready;

    assign resp       = iresp_valid && outstanding;
    assign push       = resp && !drop && !redirect_valid;

    assign out_valid  = (count != '0);
    assign out_pc     = mem[rd_ptr].pc;
    assign out_instr  = mem[rd_ptr].instr;
    assign pop        = out_valid && out_ready && !redirect_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inflight_pc <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            assert (!(push && count == CW'(DEPTH)));

            if (redirect_valid)
                pc <= redirect_pc;
            else if (accept)
                pc <= pc + PC_WIDTH'(4);

            if (accept)
                inflight_pc <= pc;

            if (accept)
                outstanding <= 1'b1;
            else if (resp)
                outstanding <= 1'b0;

            // A redirect with a response still in flight marks that response stale.
            if (resp)
                drop <= 1'b0;
            else if (redirect_valid && outstanding)
                drop <= 1'b1;

            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{pc: inflight_pc, instr: iresp_data};
    end

endmodule
